// File: rtl/pc_sequencer_if.sv
// Control and status bundle between fetch control and the PC sequencer.
// master drives the next-PC requests; slave (the sequencer) returns PC and RAS status.
interface pc_sequencer_if #(
    parameter int PC_W  = 32,
    parameter int OFF_W = 9,
    parameter int CNT_W = 3
);
    logic             stall;
    logic             halt;
    logic             branch;
    logic             zero;
    logic [OFF_W-1:0] branch_off;
    logic             jump;
    logic             call;
    logic             ret;
    logic [PC_W-1:0]  jump_target;

    logic [PC_W-1:0]  pc;
    logic             halted;
    logic             ras_overflow;
    logic             ras_underflow;
    logic [CNT_W-1:0] ras_count;

    modport master (
        output stall, halt, branch, zero, branch_off, jump, call, ret, jump_target,
        input  pc, halted, ras_overflow, ras_underflow, ras_count
    );

    modport slave (
        input  stall, halt, branch, zero, branch_off, jump, call, ret, jump_target,
        output pc, halted, ras_overflow, ras_underflow, ras_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with circular return-address stack; pc is the register (0-cycle output latency).
// stall holds PC/RAS/flags for the cycle; halt freezes everything until reset.
module pc_sequencer #(
    parameter int              PC_W      = 32,
    parameter int              STEP      = 4,
    parameter int              OFF_W     = 9,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  sif
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        RUN,
        HALTED
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PTR_W-1:0] wp_q, wp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push;
    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];

    logic [PC_W-1:0]  pc_seq;
    logic [PC_W-1:0]  off_ext;
    logic [PC_W-1:0]  br_target;
    logic [PTR_W-1:0] top_idx;
    logic             ras_empty;
    logic             ras_full;

    // Offset is sign-extended (or truncated) to PC_W first so all sums wrap mod 2^PC_W.
    assign pc_seq    = pc_q + PC_W'(STEP);
    assign off_ext   = PC_W'($signed(sif.branch_off));
    assign br_target = pc_q + off_ext * PC_W'(STEP);
    assign top_idx   = wp_q - PTR_W'(1);
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wp_d    = wp_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        case (state_q)
            RUN: begin
                if (sif.halt) begin
                    state_d = HALTED;
                end else if (!sif.stall) begin
                    if (sif.ret) begin
                        if (!ras_empty) begin
                            pc_d  = ras_mem[top_idx];
                            wp_d  = top_idx;
                            cnt_d = cnt_q - CNT_W'(1);
                        end else begin
                            pc_d  = pc_seq;
                            unf_d = 1'b1;
                        end
                    end else if (sif.call) begin
                        // When full, wp already points at the oldest entry, so the push overwrites it.
                        push = 1'b1;
                        pc_d = sif.jump_target;
                        wp_d = wp_q + PTR_W'(1);
                        if (ras_full) begin
                            ovf_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (sif.jump) begin
                        pc_d = sif.jump_target;
                    end else if (sif.branch && sif.zero) begin
                        pc_d = br_target;
                    end else begin
                        pc_d = pc_seq;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = HALTED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            wp_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wp_q    <= wp_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[wp_q] <= pc_seq;
        end
    end

    assign sif.pc            = pc_q;
    assign sif.halted        = (state_q == HALTED);
    assign sif.ras_overflow  = ovf_q;
    assign sif.ras_underflow = unf_q;
    assign sif.ras_count     = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a 32-bit instance for the main features and an 8-bit instance for wrap.
module tb_pc_sequencer;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    pc_sequencer_if #(.PC_W(32), .OFF_W(9), .CNT_W(3)) a ();
    pc_sequencer_if #(.PC_W(8),  .OFF_W(9), .CNT_W(3)) b ();

    pc_sequencer #(.PC_W(32), .STEP(4), .OFF_W(9), .RAS_DEPTH(4), .RESET_PC(32'h0)) dut_a (
        .clk(clk), .reset(reset), .sif(a)
    );
    pc_sequencer #(.PC_W(8), .STEP(4), .OFF_W(9), .RAS_DEPTH(4), .RESET_PC(8'h0)) dut_b (
        .clk(clk), .reset(reset), .sif(b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a.stall = 0; a.halt = 0; a.branch = 0; a.zero = 0; a.branch_off = '0;
        a.jump = 0; a.call = 0; a.ret = 0; a.jump_target = '0;
        b.stall = 0; b.halt = 0; b.branch = 0; b.zero = 0; b.branch_off = '0;
        b.jump = 0; b.call = 0; b.ret = 0; b.jump_target = '0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (a.pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", a.pc, 32'h0); end
        n_cmp++; if (a.halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", a.halted); end
        n_cmp++; if (a.ras_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", a.ras_count); end
        n_cmp++; if ({a.ras_overflow, a.ras_underflow} !== 2'b00) begin
            n_err++; $display("FAIL reset_flags: got %b want 00", {a.ras_overflow, a.ras_underflow});
        end
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_cmp++; if (a.pc !== 32'(i * 4)) begin n_err++; $display("FAIL seq_pc[%0d]: got %h want %h", i, a.pc, 32'(i * 4)); end
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (a.pc !== 32'h0) begin n_err++; $display("FAIL async_reset_pc: got %h want %h", a.pc, 32'h0); end
        step();
        reset = 1'b0;
    endtask

    task automatic test_branch();
        a.jump = 1; a.jump_target = 32'h20;
        step();
        a.jump = 0;
        n_cmp++; if (a.pc !== 32'h20) begin n_err++; $display("FAIL jump_pc: got %h want %h", a.pc, 32'h20); end
        a.branch = 1; a.zero = 1; a.branch_off = 9'h1FE;
        step();
        n_cmp++; if (a.pc !== 32'h18) begin n_err++; $display("FAIL branch_taken: got %h want %h", a.pc, 32'h18); end
        a.zero = 0;
        step();
        n_cmp++; if (a.pc !== 32'h1C) begin n_err++; $display("FAIL branch_not_taken: got %h want %h", a.pc, 32'h1C); end
        a.zero = 1; a.branch_off = 9'd3; a.jump = 1; a.jump_target = 32'h200;
        step();
        n_cmp++; if (a.pc !== 32'h200) begin n_err++; $display("FAIL jump_over_branch: got %h want %h", a.pc, 32'h200); end
        a.jump = 0;
        step();
        n_cmp++; if (a.pc !== 32'h20C) begin n_err++; $display("FAIL branch_fwd: got %h want %h", a.pc, 32'h20C); end
        a.branch = 0; a.zero = 0; a.branch_off = '0;
    endtask

    task automatic test_call_ret();
        a.jump = 1; a.jump_target = 32'h10;
        step();
        a.jump = 0;
        a.call = 1; a.jump = 1; a.jump_target = 32'h100;
        step();
        a.call = 0; a.jump = 0;
        n_cmp++; if (a.pc !== 32'h100) begin n_err++; $display("FAIL call_pc: got %h want %h", a.pc, 32'h100); end
        n_cmp++; if (a.ras_count !== 3'd1) begin n_err++; $display("FAIL call_count: got %0d want 1", a.ras_count); end
        a.ret = 1;
        step();
        a.ret = 0;
        n_cmp++; if (a.pc !== 32'h14) begin n_err++; $display("FAIL ret_pc: got %h want %h", a.pc, 32'h14); end
        n_cmp++; if (a.ras_count !== 3'd0) begin n_err++; $display("FAIL ret_count: got %0d want 0", a.ras_count); end
        n_cmp++; if ({a.ras_overflow, a.ras_underflow} !== 2'b00) begin
            n_err++; $display("FAIL call_ret_flags: got %b want 00", {a.ras_overflow, a.ras_underflow});
        end
    endtask

    task automatic test_overflow();
        logic [31:0] ret_exp [4];
        logic [2:0]  cnt_exp [5];
        ret_exp = '{32'h404, 32'h304, 32'h204, 32'h104};
        cnt_exp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        a.jump = 1; a.jump_target = 32'h40;
        step();
        a.jump = 0;
        for (int i = 0; i < 5; i++) begin
            a.call = 1; a.jump_target = 32'((i + 1) * 32'h100);
            step();
            n_cmp++; if (a.ras_count !== cnt_exp[i]) begin n_err++; $display("FAIL call_cnt[%0d]: got %0d want %0d", i, a.ras_count, cnt_exp[i]); end
            n_cmp++; if (a.ras_overflow !== (i == 4)) begin n_err++; $display("FAIL ovf[%0d]: got %b want %b", i, a.ras_overflow, (i == 4)); end
        end
        a.call = 0;
        n_cmp++; if (a.pc !== 32'h500) begin n_err++; $display("FAIL call5_pc: got %h want %h", a.pc, 32'h500); end
        for (int i = 0; i < 4; i++) begin
            a.ret = 1;
            step();
            n_cmp++; if (a.pc !== ret_exp[i]) begin n_err++; $display("FAIL ret_pc[%0d]: got %h want %h", i, a.pc, ret_exp[i]); end
            n_cmp++; if (a.ras_count !== 3'(3 - i)) begin n_err++; $display("FAIL ret_cnt[%0d]: got %0d want %0d", i, a.ras_count, 3 - i); end
        end
        n_cmp++; if (a.ras_underflow !== 1'b0) begin n_err++; $display("FAIL unf_early: got %b want 0", a.ras_underflow); end
        step();
        a.ret = 0;
        n_cmp++; if (a.pc !== 32'h108) begin n_err++; $display("FAIL ret_empty_pc: got %h want %h", a.pc, 32'h108); end
        n_cmp++; if ({a.ras_overflow, a.ras_underflow} !== 2'b11) begin
            n_err++; $display("FAIL sticky_flags: got %b want 11", {a.ras_overflow, a.ras_underflow});
        end
    endtask

    task automatic test_stall_halt();
        pulse_reset();
        a.stall = 1; a.jump = 1; a.jump_target = 32'h80;
        step();
        n_cmp++; if (a.pc !== 32'h0) begin n_err++; $display("FAIL stall_jump: got %h want %h", a.pc, 32'h0); end
        a.jump = 0; a.call = 1;
        step();
        n_cmp++; if ({a.pc, a.ras_count} !== {32'h0, 3'd0}) begin
            n_err++; $display("FAIL stall_call: got %h/%0d want 0/0", a.pc, a.ras_count);
        end
        a.call = 0; a.stall = 0;
        step();
        n_cmp++; if (a.pc !== 32'h4) begin n_err++; $display("FAIL unstall_pc: got %h want %h", a.pc, 32'h4); end
        a.halt = 1; a.stall = 1;
        step();
        a.halt = 0; a.stall = 0;
        n_cmp++; if (a.halted !== 1'b1) begin n_err++; $display("FAIL halted: got %b want 1", a.halted); end
        for (int i = 0; i < 10; i++) begin
            a.jump = (i % 3 == 0); a.call = (i % 3 == 1); a.ret = (i % 3 == 2);
            a.jump_target = 32'h1000 + 32'(i);
            step();
            n_cmp++; if ({a.pc, a.halted, a.ras_count} !== {32'h4, 1'b1, 3'd0}) begin
                n_err++; $display("FAIL halt_hold[%0d]: got pc=%h halted=%b cnt=%0d want pc=4 halted=1 cnt=0", i, a.pc, a.halted, a.ras_count);
            end
        end
        a.jump = 0; a.call = 0; a.ret = 0;
        reset = 1'b1;
        #1;
        n_cmp++; if ({a.pc, a.halted} !== {32'h0, 1'b0}) begin
            n_err++; $display("FAIL halt_reset: got pc=%h halted=%b want pc=0 halted=0", a.pc, a.halted);
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        pulse_reset();
        b.jump = 1; b.jump_target = 8'hFC;
        step();
        b.jump = 0;
        n_cmp++; if (b.pc !== 8'hFC) begin n_err++; $display("FAIL wrap_setup: got %h want %h", b.pc, 8'hFC); end
        step();
        n_cmp++; if (b.pc !== 8'h00) begin n_err++; $display("FAIL wrap_seq: got %h want %h", b.pc, 8'h00); end
        b.call = 1; b.ret = 1; b.jump_target = 8'h40;
        step();
        b.call = 0; b.ret = 0;
        n_cmp++; if (b.pc !== 8'h04) begin n_err++; $display("FAIL callret_pc: got %h want %h", b.pc, 8'h04); end
        n_cmp++; if ({b.ras_underflow, b.ras_overflow, b.ras_count} !== {1'b1, 1'b0, 3'd0}) begin
            n_err++; $display("FAIL callret_state: got unf=%b ovf=%b cnt=%0d want unf=1 ovf=0 cnt=0", b.ras_underflow, b.ras_overflow, b.ras_count);
        end
        b.branch = 1; b.zero = 1; b.branch_off = 9'h1FE;
        step();
        b.branch = 0; b.zero = 0;
        n_cmp++; if (b.pc !== 8'hFC) begin n_err++; $display("FAIL wrap_branch: got %h want %h", b.pc, 8'hFC); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        idle_inputs();
        repeat (3) step();
        test_reset();
        test_branch();
        test_call_ret();
        test_overflow();
        test_stall_halt();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
